queue_storage: RTL and testbench
================================

Name: queue_storage

Overview:
Data path and flag generator for the 8-entry button-driven queue. It holds the entries in a register-file memory and keeps the write and read pointers. It produces a registered read-data output. It derives isFull/isEmpty from the occupancy count supplied by queueCounter, and those flags feed back into queueCounter, so the two blocks always make identical accept/drop decisions.

Parameters:
DATA_W, 8, width of one queue entry
DEPTH, 8, number of entries; power of two, 2..8, so that the count fits 4 bits
PTR_W, 3, pointer width, log2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
write_en  input  1  write request, one-cycle pulse per push
read_en  input  1  read request, one-cycle pulse per pop
data_in  input  DATA_W  entry written on an accepted write
count_in  input  4  occupancy from queueCounter count_out
data_out  output  DATA_W  registered, last entry popped
isFull  output  1  count_in == DEPTH
isEmpty  output  1  count_in == 0
wr_ptr  output  PTR_W  next write slot, for debug LEDs
rd_ptr  output  PTR_W  next read slot, for debug LEDs
overflow_err  output  1  sticky: a write was dropped
underflow_err  output  1  sticky: a read was dropped
sync_err  output  1  sticky: internal occupancy mismatch (optional feature)

Behaviour:
- Reset (rst=1, async): wr_ptr=0, rd_ptr=0, data_out=0, overflow_err=0, underflow_err=0, sync_err=0. Memory contents are not reset and are undefined.
- isFull and isEmpty are combinational from count_in only. They must not be registered, because queueCounter samples them in the same cycle.
- Accept rules, evaluated per rising edge with the flags as they are before the edge:
  - wr_acc = write_en & !isFull
  - rd_acc = read_en & !isEmpty
  - When both requests arrive while full, only the read is accepted. When both arrive while empty, only the write is accepted. This matches queueCounter exactly.
- On wr_acc: mem[wr_ptr] <= data_in, and wr_ptr <= wr_ptr+1, wrapping modulo DEPTH (7 -> 0).
- On rd_acc: data_out <= mem[rd_ptr], and rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Read latency: data_out is valid in the cycle after the read_en edge. data_out holds its value until the next accepted read.
- Simultaneous wr_acc and rd_acc: both occur in the same edge. Occupancy is 1..DEPTH-1, so wr_ptr != rd_ptr and there is no same-address hazard.
- Overflow: if write_en & isFull, then overflow_err <= 1, memory is unchanged and wr_ptr is unchanged.
- Underflow: if read_en & isEmpty, then underflow_err <= 1, data_out is unchanged and rd_ptr is unchanged.
- Error flags clear only on rst.
- Invariant: (wr_ptr - rd_ptr) mod DEPTH == count_in mod DEPTH.
- rst asserted mid-operation: state clears immediately, and the first edge after release behaves as empty.

Optional Feature:
Macro QUEUE_STORAGE_CHECK_EN.
- Defined:
  - An internal 4-bit shadow count is reset to 0.
  - It is +1 on wr_acc only, -1 on rd_acc only, and unchanged when both or neither occur.
  - Each cycle, if shadow != count_in, then sync_err <= 1 (sticky until rst).
- Not defined: the shadow logic is absent and sync_err is tied to 0. The port exists in both builds.

Test Plan:
1. Reset, then push 0x11,0x22,0x33 (count_in tracks 1,2,3), then pop 3 times -> data_out is 0x11, 0x22, 0x33 one cycle after each read_en; rd_ptr=3; no error flags set.
2. Push 8 entries 0xA0..0xA7 -> isFull=1 at count_in=8; a 9th write with 0xFF sets overflow_err=1, wr_ptr stays 0, and the next 8 pops return 0xA0..0xA7.
3. From empty, read_en pulse -> underflow_err=1, data_out unchanged, rd_ptr=0; then write_en+read_en together while empty -> write only, wr_ptr=1, rd_ptr=0.
4. Full queue with write_en+read_en together -> read only: data_out = oldest entry, rd_ptr+1, wr_ptr unchanged, overflow_err=1.
5. At count 3, simultaneous write 0x5C and read -> oldest entry popped, 0x5C stored, both pointers +1. Then cycle 20 push/pop pairs -> pointers wrap 7->0 correctly and data order is preserved.
6. With QUEUE_STORAGE_CHECK_EN, force count_in off by one for one cycle -> sync_err=1 next edge, held until rst. Without the macro, sync_err stays 0.

Source files
------------

// File: rtl/queue_storage_if.sv
// Bus bundle between queueCounter-side logic (master) and queue_storage (slave).
// write_en/read_en are single-cycle request pulses; there is no ready: a request is
// taken on the rising edge unless isFull/isEmpty (from count_in) refuse it.
interface queue_storage_if #(
  parameter int DATA_W = 8,
  parameter int PTR_W  = 3
);
  logic              write_en;
  logic              read_en;
  logic [DATA_W-1:0] data_in;
  logic [3:0]        count_in;
  logic [DATA_W-1:0] data_out;
  logic              isFull;
  logic              isEmpty;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              overflow_err;
  logic              underflow_err;
  logic              sync_err;

  modport master (
    output write_en, read_en, data_in, count_in,
    input  data_out, isFull, isEmpty, wr_ptr, rd_ptr,
    input  overflow_err, underflow_err, sync_err
  );

  modport slave (
    input  write_en, read_en, data_in, count_in,
    output data_out, isFull, isEmpty, wr_ptr, rd_ptr,
    output overflow_err, underflow_err, sync_err
  );
endinterface

// File: rtl/queue_storage.sv
// Storage, pointers and full/empty flags for the 8-entry button queue.
// Optional occupancy cross-check against count_in is enabled by QUEUE_STORAGE_CHECK_EN.
module queue_storage #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input logic            clk,
  input logic            rst,
  queue_storage_if.slave bus
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              is_full, is_empty;
  logic              wr_acc, rd_acc;

  // Flags stay combinational: queueCounter samples them in the same cycle.
  assign is_full  = (bus.count_in == 4'(DEPTH));
  assign is_empty = (bus.count_in == 4'd0);
  assign wr_acc   = bus.write_en & ~is_full;
  assign rd_acc   = bus.read_en & ~is_empty;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    data_out_d  = data_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_acc) begin
      mem_d[wr_ptr_q] = bus.data_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    // Reading mem_q (pre-edge) is safe: both accepted implies wr_ptr != rd_ptr.
    if (rd_acc) begin
      data_out_d = mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
    end
    if (bus.write_en && is_full) begin
      overflow_d = 1'b1;
    end
    if (bus.read_en && is_empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.isFull        = is_full;
  assign bus.isEmpty       = is_empty;
  assign bus.wr_ptr        = wr_ptr_q;
  assign bus.rd_ptr        = rd_ptr_q;
  assign bus.data_out      = data_out_q;
  assign bus.overflow_err  = overflow_q;
  assign bus.underflow_err = underflow_q;

`ifdef QUEUE_STORAGE_CHECK_EN
  logic [3:0] shadow_q, shadow_d;
  logic       sync_err_q, sync_err_d;

  // Shadow mirrors queueCounter; any divergence from count_in latches sync_err.
  always_comb begin
    shadow_d   = shadow_q;
    sync_err_d = sync_err_q | (shadow_q != bus.count_in);
    if (wr_acc && !rd_acc) begin
      shadow_d = shadow_q + 4'd1;
    end else if (rd_acc && !wr_acc) begin
      shadow_d = shadow_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= 4'd0;
      sync_err_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign bus.sync_err = sync_err_q;
`else
  assign bus.sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_queue_storage.sv
// Self-checking bench for queue_storage; the bench plays queueCounter by driving count_in.
module tb_queue_storage;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;

  logic clk;
  logic rst;
  queue_storage_if #(.DATA_W(DATA_W), .PTR_W(PTR_W)) bus ();

  queue_storage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // queueCounter stand-in plus scoreboard state
  int                model_count;
  int                exp_wr;
  int                exp_rd;
  logic              exp_ovf;
  logic              exp_unf;
  logic              exp_sync;
  logic [DATA_W-1:0] model_fifo[$];
  logic [DATA_W-1:0] exp_q[$];

  typedef struct {
    logic              we;
    logic              re;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] exp_data;
    logic [PTR_W-1:0]  exp_wr;
    logic [PTR_W-1:0]  exp_rd;
    logic              exp_full;
    logic              exp_empty;
    logic              exp_ovf;
    logic              exp_unf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    model_count = 0;
    exp_wr      = 0;
    exp_rd      = 0;
    exp_ovf     = 1'b0;
    exp_unf     = 1'b0;
    exp_sync    = 1'b0;
    model_fifo.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    bus.data_in  = '0;
    bus.count_in = 4'd0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_ptr", 32'(bus.wr_ptr), 32'd0);
    check("rst_rd_ptr", 32'(bus.rd_ptr), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_ovf", 32'(bus.overflow_err), 32'd0);
    check("rst_unf", 32'(bus.underflow_err), 32'd0);
    check("rst_sync", 32'(bus.sync_err), 32'd0);
    check("rst_empty", 32'(bus.isEmpty), 32'd1);
    check("rst_full", 32'(bus.isFull), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // driver: one request cycle, then scoreboard and pointer checks after the edge
  task automatic step(input logic we, input logic re, input logic [DATA_W-1:0] din);
    logic              wa;
    logic              ra;
    logic [DATA_W-1:0] exp;
    @(negedge clk);
    bus.write_en = we;
    bus.read_en  = re;
    bus.data_in  = din;
    wa = we && (model_count != DEPTH);
    ra = re && (model_count != 0);
    if (we && !wa) exp_ovf = 1'b1;
    if (re && !ra) exp_unf = 1'b1;
    if (ra) exp_q.push_back(model_fifo.pop_front());
    if (wa) model_fifo.push_back(din);
    @(posedge clk);
    #1;
    model_count  = model_count + int'(wa) - int'(ra);
    bus.count_in = 4'(model_count);
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    if (wa) exp_wr = (exp_wr + 1) % DEPTH;
    if (ra) exp_rd = (exp_rd + 1) % DEPTH;
    if (ra) begin
      exp = exp_q.pop_front();
      check("sb_data_out", 32'(bus.data_out), 32'(exp));
    end
    check("wr_ptr", 32'(bus.wr_ptr), 32'(exp_wr));
    check("rd_ptr", 32'(bus.rd_ptr), 32'(exp_rd));
    check("overflow_err", 32'(bus.overflow_err), 32'(exp_ovf));
    check("underflow_err", 32'(bus.underflow_err), 32'(exp_unf));
    check("sync_err", 32'(bus.sync_err), 32'(exp_sync));
    check("isFull", 32'(bus.isFull), 32'(model_count == DEPTH));
    check("isEmpty", 32'(bus.isEmpty), 32'(model_count == 0));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;

    // push 11,22,33, pop three, underflow, simultaneous request while empty
    vecs[0] = '{1'b1, 1'b0, 8'h11, 8'h00, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h22, 8'h00, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h33, 8'h00, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h11, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h22, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h33, 3'd3, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h33, 3'd3, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 8'h44, 8'h33, 3'd4, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 8'h00, 8'h44, 3'd4, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1};

    do_reset();

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].we, vecs[i].re, vecs[i].din);
      check($sformatf("vec%0d_data", i), 32'(bus.data_out), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_wr", i), 32'(bus.wr_ptr), 32'(vecs[i].exp_wr));
      check($sformatf("vec%0d_rd", i), 32'(bus.rd_ptr), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d_full", i), 32'(bus.isFull), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d_empty", i), 32'(bus.isEmpty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d_ovf", i), 32'(bus.overflow_err), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_unf", i), 32'(bus.underflow_err), 32'(vecs[i].exp_unf));
    end

    // asynchronous reset mid-operation, then first edge behaves as empty
    step(1'b1, 1'b0, 8'h66);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_wr", 32'(bus.wr_ptr), 32'd0);
    check("async_rst_rd", 32'(bus.rd_ptr), 32'd0);
    check("async_rst_unf", 32'(bus.underflow_err), 32'd0);
    do_reset();
    step(1'b0, 1'b1, 8'h00);
    check("post_rst_unf_data", 32'(bus.data_out), 32'd0);

    // fill to full, overflow, then simultaneous request while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i));
    check("full_at_8", 32'(bus.isFull), 32'd1);
    step(1'b1, 1'b0, 8'hFF);
    check("ovf_set", 32'(bus.overflow_err), 32'd1);
    check("ovf_wr_hold", 32'(bus.wr_ptr), 32'd0);
    step(1'b1, 1'b1, 8'hEE);
    check("full_both_data", 32'(bus.data_out), 32'hA0);
    check("full_both_rd", 32'(bus.rd_ptr), 32'd1);
    check("full_both_wr", 32'(bus.wr_ptr), 32'd0);
    for (int i = 1; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
    check("drained_data", 32'(bus.data_out), 32'hA7);

    // simultaneous push/pop at count 3, then pairs that wrap the pointers
    do_reset();
    step(1'b1, 1'b0, 8'hB0);
    step(1'b1, 1'b0, 8'hB1);
    step(1'b1, 1'b0, 8'hB2);
    step(1'b1, 1'b1, 8'h5C);
    check("pair_data", 32'(bus.data_out), 32'hB0);
    check("pair_wr", 32'(bus.wr_ptr), 32'd4);
    check("pair_rd", 32'(bus.rd_ptr), 32'd1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
    check("wrap_wr", 32'(bus.wr_ptr), 32'd0);
    check("wrap_rd", 32'(bus.rd_ptr), 32'd5);

    // random mixed traffic
    for (int i = 0; i < 120; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    // occupancy disagreement for one cycle
    @(negedge clk);
    bus.count_in = 4'(model_count + 1);
    @(posedge clk);
    #1;
    bus.count_in = 4'(model_count);
`ifdef QUEUE_STORAGE_CHECK_EN
    exp_sync = 1'b1;
`endif
    check("sync_err_set", 32'(bus.sync_err), 32'(exp_sync));
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check("sync_err_hold", 32'(bus.sync_err), 32'(exp_sync));
    do_reset();
    check("sync_err_cleared", 32'(bus.sync_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
